cook_timer_controller: RTL and testbench

//  Sequences the microwave cook timer. Captures the BCD time (M:SS) produced by the

---
 rtl/timer_pkg.sv | 22 ++
 rtl/bcd_time_decrementer.sv | 41 ++++
 rtl/cook_timer_controller.sv | 173 +++++++++++++++++
 tb/tb_cook_timer_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared encodings for the microwave cook timer.
// Holds FSM state codes, BCD digit limits and the load clamp helper.
package timer_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOADED  = 3'd1;
   localparam logic [2:0] ST_COOKING = 3'd2;
   localparam logic [2:0] ST_PAUSED  = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   localparam logic [3:0] BCD_MAX_SEC  = 4'd9;
   localparam logic [3:0] BCD_MAX_TENS = 4'd5;
   localparam logic [3:0] BCD_MAX_MIN  = 4'd9;

   function automatic logic [3:0] bcd_clamp(
      input logic [3:0] v,
      input logic [3:0] lim
   );
      return (v > lim) ? lim : v;
   endfunction

endpackage

// File: rtl/bcd_time_decrementer.sv
// Combinational M:SS minus one second with BCD borrow.
// Ports: min/tens/sec in, decremented digits out, zero_o (input 0:00), last_o (result 0:00).
module bcd_time_decrementer
   import timer_pkg::*;
(
   input  logic [3:0] min_i,
   input  logic [3:0] tens_i,
   input  logic [3:0] sec_i,
   output logic [3:0] min_o,
   output logic [3:0] tens_o,
   output logic [3:0] sec_o,
   output logic       zero_o,
   output logic       last_o
);

   assign zero_o = (min_i == 4'd0) && (tens_i == 4'd0) &&
                   (sec_i == 4'd0);
   assign last_o = (min_i == 4'd0) && (tens_i == 4'd0) &&
                   (sec_i == 4'd1);

   always_comb begin
      min_o  = min_i;
      tens_o = tens_i;
      sec_o  = sec_i;
      // 0:00 saturates rather than wrapping to 9:59
      if (!zero_o) begin
         if (sec_i != 4'd0) begin
            sec_o = sec_i - 4'd1;
         end else begin
            sec_o = BCD_MAX_SEC;
            if (tens_i != 4'd0) begin
               tens_o = tens_i - 4'd1;
            end else begin
               tens_o = BCD_MAX_TENS;
               min_o  = min_i - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/cook_timer_controller.sv
// Microwave cook timer: loads M:SS, counts down once per second while cooking.
// Ports: clk/clearn, loadn+digits in, startn/stopn/door_closed, BCD digits, mag_on, done, state_o out.
module cook_timer_controller
   import timer_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int CNT_W         = 26
)(
   input  logic       clk,
   input  logic       clearn,
   input  logic       loadn,
   input  logic [3:0] min_in,
   input  logic [3:0] tens_sec_in,
   input  logic [3:0] sec_in,
   input  logic       startn,
   input  logic       stopn,
   input  logic       door_closed,
   output logic [3:0] units_of_minutes,
   output logic [3:0] tens_of_seconds,
   output logic [3:0] units_of_seconds,
   output logic       mag_on,
   output logic       done,
   output logic [2:0] state_o
);

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_SEC - 1);

   logic [2:0]       state_q, state_d;
   logic [3:0]       min_q, min_d;
   logic [3:0]       tens_q, tens_d;
   logic [3:0]       sec_q, sec_d;
   logic [CNT_W-1:0] presc_q, presc_d;
   logic             mag_q, mag_d;
   logic             done_q, done_d;

   logic [3:0] dec_min, dec_tens, dec_sec;
   logic       dec_zero, dec_last;
   logic [3:0] ld_min, ld_tens, ld_sec;
   logic       ld_zero;
   logic       tick;
   logic       start_ok;

   bcd_time_decrementer u_dec (
      .min_i  (min_q),
      .tens_i (tens_q),
      .sec_i  (sec_q),
      .min_o  (dec_min),
      .tens_o (dec_tens),
      .sec_o  (dec_sec),
      .zero_o (dec_zero),
      .last_o (dec_last)
   );

   assign ld_min  = bcd_clamp(min_in, BCD_MAX_MIN);
   assign ld_tens = bcd_clamp(tens_sec_in, BCD_MAX_TENS);
   assign ld_sec  = bcd_clamp(sec_in, BCD_MAX_SEC);
   assign ld_zero = (ld_min == 4'd0) && (ld_tens == 4'd0) &&
                    (ld_sec == 4'd0);

   assign tick     = (presc_q == TICK_LAST);
   assign start_ok = !startn && door_closed && !dec_zero;

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      tens_d  = tens_q;
      sec_d   = sec_q;
      presc_d = presc_q;
      case (state_q)
         ST_IDLE: begin
            if (stopn && !loadn) begin
               min_d   = ld_min;
               tens_d  = ld_tens;
               sec_d   = ld_sec;
               state_d = ld_zero ? ST_IDLE : ST_LOADED;
            end
         end
         ST_LOADED: begin
            if (!stopn) begin
               min_d   = '0;
               tens_d  = '0;
               sec_d   = '0;
               state_d = ST_IDLE;
            end else if (!loadn) begin
               min_d   = ld_min;
               tens_d  = ld_tens;
               sec_d   = ld_sec;
               state_d = ld_zero ? ST_IDLE : ST_LOADED;
            end else if (start_ok) begin
               presc_d = '0;
               state_d = ST_COOKING;
            end
         end
         ST_COOKING: begin
            // door/stop freeze count and prescaler; a coincident tick is lost
            if (!door_closed || !stopn) begin
               state_d = ST_PAUSED;
            end else if (tick) begin
               presc_d = '0;
               min_d   = dec_min;
               tens_d  = dec_tens;
               sec_d   = dec_sec;
               if (dec_last) state_d = ST_DONE;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         ST_PAUSED: begin
            if (!stopn) begin
               min_d   = '0;
               tens_d  = '0;
               sec_d   = '0;
               state_d = ST_IDLE;
            end else if (start_ok) begin
               presc_d = '0;
               state_d = ST_COOKING;
            end
         end
         ST_DONE: begin
            if (!door_closed || !stopn) begin
               min_d   = '0;
               tens_d  = '0;
               sec_d   = '0;
               state_d = ST_IDLE;
            end else if (!loadn) begin
               min_d   = ld_min;
               tens_d  = ld_tens;
               sec_d   = ld_sec;
               state_d = ld_zero ? ST_IDLE : ST_LOADED;
            end
         end
         default: begin
            min_d   = '0;
            tens_d  = '0;
            sec_d   = '0;
            presc_d = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Moore outputs registered from next state
   assign mag_d  = (state_d == ST_COOKING) && door_closed;
   assign done_d = (state_d == ST_DONE);

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         state_q <= ST_IDLE;
         min_q   <= '0;
         tens_q  <= '0;
         sec_q   <= '0;
         presc_q <= '0;
         mag_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         tens_q  <= tens_d;
         sec_q   <= sec_d;
         presc_q <= presc_d;
         mag_q   <= mag_d;
         done_q  <= done_d;
      end
   end

   assign units_of_minutes = min_q;
   assign tens_of_seconds  = tens_q;
   assign units_of_seconds = sec_q;
   assign mag_on           = mag_q;
   assign done             = done_q;
   assign state_o          = state_q;

endmodule

// File: tb/tb_cook_timer_controller.sv
// Scoreboard bench for cook_timer_controller with a 4-cycle second.
// Stimulus queues expected status; a negedge monitor pops and compares.
module tb_cook_timer_controller;
   import timer_pkg::*;

   logic       clk = 1'b0;
   logic       clearn;
   logic       loadn;
   logic [3:0] min_in;
   logic [3:0] tens_sec_in;
   logic [3:0] sec_in;
   logic       startn;
   logic       stopn;
   logic       door_closed;
   logic [3:0] units_of_minutes;
   logic [3:0] tens_of_seconds;
   logic [3:0] units_of_seconds;
   logic       mag_on;
   logic       done;
   logic [2:0] state_o;

   cook_timer_controller #(
      .TICKS_PER_SEC (4),
      .CNT_W         (3)
   ) dut (
      .clk              (clk),
      .clearn           (clearn),
      .loadn            (loadn),
      .min_in           (min_in),
      .tens_sec_in      (tens_sec_in),
      .sec_in           (sec_in),
      .startn           (startn),
      .stopn            (stopn),
      .door_closed      (door_closed),
      .units_of_minutes (units_of_minutes),
      .tens_of_seconds  (tens_of_seconds),
      .units_of_seconds (units_of_seconds),
      .mag_on           (mag_on),
      .done             (done),
      .state_o          (state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [2:0] st;
      logic [3:0] m;
      logic [3:0] t;
      logic [3:0] s;
      logic       mag;
      logic       dn;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;

   task automatic expect_out(input string name, input logic [2:0] st,
                             input logic [3:0] m, input logic [3:0] t,
                             input logic [3:0] s, input logic mag,
                             input logic dn);
      exp_t e;
      e.name = name;
      e.st   = st;
      e.m    = m;
      e.t    = t;
      e.s    = s;
      e.mag  = mag;
      e.dn   = dn;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         vectors++;
         if (state_o !== mon_e.st || units_of_minutes !== mon_e.m ||
             tens_of_seconds !== mon_e.t ||
             units_of_seconds !== mon_e.s ||
             mag_on !== mon_e.mag || done !== mon_e.dn) begin
            miscompares++;
            $display("FAIL %s: got st=%0d %0d:%0d%0d mag=%0b done=%0b, want st=%0d %0d:%0d%0d mag=%0b done=%0b",
                     mon_e.name, state_o, units_of_minutes,
                     tens_of_seconds, units_of_seconds, mag_on, done,
                     mon_e.st, mon_e.m, mon_e.t, mon_e.s, mon_e.mag,
                     mon_e.dn);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] m, input logic [3:0] t,
                       input logic [3:0] s);
      min_in      = m;
      tens_sec_in = t;
      sec_in      = s;
      loadn       = 1'b0;
      step();
      loadn       = 1'b1;
   endtask

   task automatic start_pulse();
      startn = 1'b0;
      step();
      startn = 1'b1;
   endtask

   task automatic stop_pulse();
      stopn = 1'b0;
      step();
      stopn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: sim time expired, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clearn      = 1'b0;
      loadn       = 1'b1;
      startn      = 1'b1;
      stopn       = 1'b1;
      door_closed = 1'b1;
      min_in      = 4'd0;
      tens_sec_in = 4'd0;
      sec_in      = 4'd0;
      #1;
      expect_out("reset", ST_IDLE, 0, 0, 0, 0, 0);
      step();
      clearn = 1'b1;
      step();

      // 1:05 countdown with minute borrow
      load(1, 0, 5);
      expect_out("load_105", ST_LOADED, 1, 0, 5, 0, 0);
      start_pulse();
      expect_out("start_105", ST_COOKING, 1, 0, 5, 1, 0);
      step(3);
      expect_out("pre_tick", ST_COOKING, 1, 0, 5, 1, 0);
      step(1);
      expect_out("tick_104", ST_COOKING, 1, 0, 4, 1, 0);
      step(20);
      expect_out("borrow_059", ST_COOKING, 0, 5, 9, 1, 0);
      stop_pulse();
      expect_out("stop_pause", ST_PAUSED, 0, 5, 9, 0, 0);
      stop_pulse();
      expect_out("stop_clear", ST_IDLE, 0, 0, 0, 0, 0);

      // run to DONE, reload from DONE, door open from DONE
      load(0, 0, 2);
      expect_out("load_002", ST_LOADED, 0, 0, 2, 0, 0);
      start_pulse();
      step(4);
      expect_out("tick_001", ST_COOKING, 0, 0, 1, 1, 0);
      step(4);
      expect_out("done_000", ST_DONE, 0, 0, 0, 0, 1);
      load(0, 0, 3);
      expect_out("load_from_done", ST_LOADED, 0, 0, 3, 0, 0);
      start_pulse();
      step(12);
      expect_out("done_again", ST_DONE, 0, 0, 0, 0, 1);
      door_closed = 1'b0;
      step();
      expect_out("door_in_done", ST_IDLE, 0, 0, 0, 0, 0);
      door_closed = 1'b1;

      // door pause mid-second, held start, resume timing
      load(0, 3, 0);
      expect_out("load_030", ST_LOADED, 0, 3, 0, 0, 0);
      start_pulse();
      step(4);
      expect_out("tick_029", ST_COOKING, 0, 2, 9, 1, 0);
      step(2);
      door_closed = 1'b0;
      step();
      expect_out("door_pause", ST_PAUSED, 0, 2, 9, 0, 0);
      startn      = 1'b0;
      loadn       = 1'b0;
      min_in      = 4'd5;
      tens_sec_in = 4'd5;
      sec_in      = 4'd5;
      step(2);
      expect_out("held_start_open", ST_PAUSED, 0, 2, 9, 0, 0);
      loadn       = 1'b1;
      door_closed = 1'b1;
      step();
      expect_out("resume", ST_COOKING, 0, 2, 9, 1, 0);
      startn = 1'b1;
      step(3);
      expect_out("resume_pre", ST_COOKING, 0, 2, 9, 1, 0);
      step(1);
      expect_out("resume_tick", ST_COOKING, 0, 2, 8, 1, 0);
      stop_pulse();
      stop_pulse();
      expect_out("clear_after", ST_IDLE, 0, 0, 0, 0, 0);

      // zero load, start in IDLE, clamp
      load(0, 0, 0);
      expect_out("load_zero", ST_IDLE, 0, 0, 0, 0, 0);
      start_pulse();
      expect_out("start_idle", ST_IDLE, 0, 0, 0, 0, 0);
      load(12, 7, 12);
      expect_out("clamp_959", ST_LOADED, 9, 5, 9, 0, 0);
      stop_pulse();
      expect_out("stop_loaded", ST_IDLE, 0, 0, 0, 0, 0);

      // asynchronous reset mid-cook
      load(0, 4, 5);
      start_pulse();
      expect_out("cook_045", ST_COOKING, 0, 4, 5, 1, 0);
      step(2);
      clearn = 1'b0;
      expect_out("async_reset", ST_IDLE, 0, 0, 0, 0, 0);
      step();
      clearn = 1'b1;
      step();
      expect_out("after_reset", ST_IDLE, 0, 0, 0, 0, 0);

      step(2);
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
